// File: rtl/pll_seq_pkg.sv
// Shared types, reset defaults and helpers for the PLL reprogramming sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GATE,
    RESET,
    LOCK,
    UNGATE
  } pll_state_e;

  // Field order matches {cfg_mul, cfg_div, cfg_bp}, where cfg_div is {OD[2:0], N[4:0]}
  typedef struct packed {
    logic [7:0] mul;
    logic [2:0] od;
    logic [4:0] n;
    logic       bp;
  } pll_cfg_t;

  localparam logic [7:0] MUL_MIN = 8'd8;
  localparam logic [7:0] MUL_MAX = 8'd120;
  localparam logic [7:0] DEF_MUL = 8'd46;
  localparam logic [7:0] DEF_DIV = 8'h22;

  localparam pll_cfg_t DEF_CFG = {DEF_MUL, DEF_DIV, 1'b0};

  // A setting is usable when M is inside the PLL's supported range and N is non-zero
  function automatic logic cfg_legal(input pll_cfg_t c);
    return (c.mul >= MUL_MIN) && (c.mul <= MUL_MAX) && (c.n != 5'd0);
  endfunction

  // Converts a cycle count into a counter load value; zero is stretched to one cycle
  function automatic logic [15:0] load_count(input int unsigned cycles);
    logic [15:0] v;
    v = cycles[15:0];
    return (cycles == 0) ? 16'd1 : v;
  endfunction

endpackage

// File: rtl/pll_cfg_debounce.sv
// Captures the requested PLL setting every cycle and reports once it has stopped changing.
module pll_cfg_debounce
  import pll_seq_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] cfg_mul,
  input  logic [7:0] cfg_div,
  input  logic       cfg_bp,
  output logic       stable,
  output pll_cfg_t   shadow
);

  localparam logic [15:0] STABLE_MAX = 16'(STABLE_CYCLES);

  pll_cfg_t    cfg_in;
  pll_cfg_t    shadow_q;
  logic [15:0] stable_cnt_q;
  logic [15:0] stable_cnt_d;

  assign cfg_in = {cfg_mul, cfg_div, cfg_bp};

  // Any difference from the previous capture restarts the stability count; otherwise count up and saturate
  always_comb begin
    stable_cnt_d = stable_cnt_q;
    if (cfg_in != shadow_q) begin
      stable_cnt_d = '0;
    end else if (stable_cnt_q < STABLE_MAX) begin
      stable_cnt_d = stable_cnt_q + 16'd1;
    end
  end

  // Shadow register and stability counter; the shadow starts at the power-on defaults
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q     <= DEF_CFG;
      stable_cnt_q <= '0;
    end else begin
      shadow_q     <= cfg_in;
      stable_cnt_q <= stable_cnt_d;
    end
  end

  assign stable = (stable_cnt_q >= STABLE_MAX);
  assign shadow = shadow_q;

endmodule

// File: rtl/pll_reconfig_seq.sv
// Sequences a safe runtime reprogram of one PLL: gate OE, pulse RESET with the new M/N/OD,
// wait for lock, re-enable OE and finally release the downstream domain reset request.
module pll_reconfig_seq
  import pll_seq_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 256,
  parameter int unsigned GATE_CYCLES   = 16,
  parameter int unsigned RESET_CYCLES  = 64,
  parameter int unsigned LOCK_CYCLES   = 12500,
  parameter int unsigned SETTLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] cfg_mul,
  input  logic [7:0] cfg_div,
  input  logic       cfg_bp,
  input  logic       cfg_oe,
  output logic [8:0] pll_m,
  output logic [4:0] pll_n,
  output logic [3:0] pll_od,
  output logic       pll_bp,
  output logic       pll_rst,
  output logic       pll_oe,
  output logic       domain_rst_req,
  output logic       busy,
  output logic       cfg_err
);

  localparam logic [15:0] GATE_LOAD   = load_count(GATE_CYCLES);
  localparam logic [15:0] RESET_LOAD  = load_count(RESET_CYCLES);
  localparam logic [15:0] LOCK_LOAD   = load_count(LOCK_CYCLES);
  localparam logic [15:0] SETTLE_LOAD = load_count(SETTLE_CYCLES);

  logic       stable;
  pll_cfg_t   shadow;
  logic       pending;
  logic       legal;

  pll_state_e  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  pll_cfg_t    applied_q, applied_d;
  logic        pll_rst_q, pll_rst_d;
  logic        pll_oe_q, pll_oe_d;
  logic        dom_rst_q, dom_rst_d;
  logic        busy_q, busy_d;
  logic        cfg_err_q, cfg_err_d;

  pll_state_e  adv_state;
  logic [15:0] cur_load;
  logic [15:0] adv_load;

  pll_cfg_debounce #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .reset  (reset),
    .cfg_mul(cfg_mul),
    .cfg_div(cfg_div),
    .cfg_bp (cfg_bp),
    .stable (stable),
    .shadow (shadow)
  );

  assign pending = stable && (shadow != applied_q);
  assign legal   = cfg_legal(shadow);

  // Next state, shared down-counter, applied setting and next-cycle output values
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    applied_d = applied_q;
    cfg_err_d = cfg_err_q;
    cur_load  = 16'd1;
    adv_state = IDLE;
    adv_load  = '0;

    case (state_q)
      GATE: begin
        cur_load  = GATE_LOAD;
        adv_state = RESET;
        adv_load  = RESET_LOAD;
      end
      RESET: begin
        cur_load  = RESET_LOAD;
        adv_state = LOCK;
        adv_load  = LOCK_LOAD;
      end
      LOCK: begin
        cur_load  = LOCK_LOAD;
        adv_state = UNGATE;
        adv_load  = SETTLE_LOAD;
      end
      UNGATE: begin
        cur_load  = SETTLE_LOAD;
        adv_state = IDLE;
        adv_load  = '0;
      end
      default: begin
        cur_load  = 16'd1;
        adv_state = IDLE;
        adv_load  = '0;
      end
    endcase

    if (state_q == IDLE) begin
      cnt_d = '0;
      if (pending) begin
        if (legal) begin
          state_d   = GATE;
          cnt_d     = GATE_LOAD;
          cfg_err_d = 1'b0;
        end else begin
          cfg_err_d = 1'b1;
        end
      end
    end else if (cnt_q == 16'd0) begin
      // A zero count only exists straight out of reset: load this state's duration first
      cnt_d = cur_load;
    end else if (cnt_q == 16'd1) begin
      state_d = adv_state;
      cnt_d   = adv_load;
      // Whatever the shadow holds on RESET entry is applied, provided the PLL can accept it
      if ((adv_state == RESET) && legal) begin
        applied_d = shadow;
      end
    end else begin
      cnt_d = cnt_q - 16'd1;
    end

    pll_rst_d = (state_d == RESET);
    pll_oe_d  = ((state_d == IDLE) || (state_d == UNGATE)) ? cfg_oe : 1'b0;
    dom_rst_d = (state_d != IDLE);
    busy_d    = (state_d != IDLE);
  end

  // State, counter and output registers; reset starts with a full power-on lock wait
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= LOCK;
      cnt_q     <= '0;
      applied_q <= DEF_CFG;
      pll_rst_q <= 1'b0;
      pll_oe_q  <= 1'b0;
      dom_rst_q <= 1'b1;
      busy_q    <= 1'b1;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      applied_q <= applied_d;
      pll_rst_q <= pll_rst_d;
      pll_oe_q  <= pll_oe_d;
      dom_rst_q <= dom_rst_d;
      busy_q    <= busy_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign pll_m          = {1'b0, applied_q.mul};
  assign pll_n          = applied_q.n;
  assign pll_od         = {1'b0, applied_q.od};
  assign pll_bp         = applied_q.bp;
  assign pll_rst        = pll_rst_q;
  assign pll_oe         = pll_oe_q;
  assign domain_rst_req = dom_rst_q;
  assign busy           = busy_q;
  assign cfg_err        = cfg_err_q;

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Directed bench for pll_reconfig_seq with a shortened lock wait.
module tb_pll_reconfig_seq;

  localparam int ST  = 256;
  localparam int G   = 16;
  localparam int R   = 64;
  localparam int L   = 400;
  localparam int S   = 16;
  localparam int SEQ = 1 + G + R + L + S;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] cfg_mul;
  logic [7:0] cfg_div;
  logic       cfg_bp;
  logic       cfg_oe;
  logic [8:0] pll_m;
  logic [4:0] pll_n;
  logic [3:0] pll_od;
  logic       pll_bp;
  logic       pll_rst;
  logic       pll_oe;
  logic       domain_rst_req;
  logic       busy;
  logic       cfg_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int c;
  int t;

  pll_reconfig_seq #(
    .STABLE_CYCLES(ST),
    .GATE_CYCLES  (G),
    .RESET_CYCLES (R),
    .LOCK_CYCLES  (L),
    .SETTLE_CYCLES(S)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cfg_mul       (cfg_mul),
    .cfg_div       (cfg_div),
    .cfg_bp        (cfg_bp),
    .cfg_oe        (cfg_oe),
    .pll_m         (pll_m),
    .pll_n         (pll_n),
    .pll_od        (pll_od),
    .pll_bp        (pll_bp),
    .pll_rst       (pll_rst),
    .pll_oe        (pll_oe),
    .domain_rst_req(domain_rst_req),
    .busy          (busy),
    .cfg_err       (cfg_err)
  );

  always #20 clk = ~clk;

  task automatic stepCycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic runTo(input int target);
    while (cyc < target) stepCycle();
  endtask

  task automatic applyStimulus(input logic [7:0] mul, input logic [7:0] div, input logic oe);
    cfg_mul = mul;
    cfg_div = div;
    cfg_bp  = 1'b0;
    cfg_oe  = oe;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  initial begin
    // Power-on: hold defaults through reset and the initial lock wait
    reset = 1'b1;
    applyStimulus(8'd46, 8'h22, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;
    checkOutput("rst_pll_m", 16'(pll_m), 16'd46);
    checkOutput("rst_pll_n", 16'(pll_n), 16'd2);
    checkOutput("rst_pll_od", 16'(pll_od), 16'd1);
    checkOutput("rst_pll_bp", 16'(pll_bp), 16'd0);
    checkOutput("rst_pll_rst", 16'(pll_rst), 16'd0);
    checkOutput("rst_pll_oe", 16'(pll_oe), 16'd0);
    checkOutput("rst_dom", 16'(domain_rst_req), 16'd1);
    checkOutput("rst_busy", 16'(busy), 16'd1);
    checkOutput("rst_err", 16'(cfg_err), 16'd0);
    runTo(L);
    checkOutput("po_oe_lock", 16'(pll_oe), 16'd0);
    runTo(L + 1);
    checkOutput("po_oe_ungate", 16'(pll_oe), 16'd1);
    runTo(L + S);
    checkOutput("po_dom_hold", 16'(domain_rst_req), 16'd1);
    runTo(L + S + 1);
    checkOutput("po_dom_rel", 16'(domain_rst_req), 16'd0);
    checkOutput("po_busy", 16'(busy), 16'd0);

    // Legal reprogram to M=30, N=1
    c = cyc;
    applyStimulus(8'd30, 8'h21, 1'b1);
    t = c + ST + 1;
    runTo(t);
    checkOutput("s1_oe_pre", 16'(pll_oe), 16'd1);
    checkOutput("s1_busy_pre", 16'(busy), 16'd0);
    runTo(t + 1);
    checkOutput("s1_oe_gate", 16'(pll_oe), 16'd0);
    checkOutput("s1_dom_gate", 16'(domain_rst_req), 16'd1);
    runTo(t + G);
    checkOutput("s1_rst_pre", 16'(pll_rst), 16'd0);
    checkOutput("s1_m_pre", 16'(pll_m), 16'd46);
    runTo(t + G + 1);
    checkOutput("s1_rst_on", 16'(pll_rst), 16'd1);
    runTo(t + G + R);
    checkOutput("s1_rst_last", 16'(pll_rst), 16'd1);
    runTo(t + G + R + 1);
    checkOutput("s1_rst_off", 16'(pll_rst), 16'd0);
    checkOutput("s1_m", 16'(pll_m), 16'd30);
    checkOutput("s1_n", 16'(pll_n), 16'd1);
    runTo(t + SEQ - 1);
    checkOutput("s1_dom_hold", 16'(domain_rst_req), 16'd1);
    runTo(t + SEQ);
    checkOutput("s1_dom_rel", 16'(domain_rst_req), 16'd0);
    checkOutput("s1_busy_end", 16'(busy), 16'd0);
    checkOutput("s1_oe_end", 16'(pll_oe), 16'd1);

    // Two writes 100 cycles apart produce a single sequence timed from the second
    c = cyc;
    applyStimulus(8'd50, 8'h21, 1'b1);
    runTo(c + 100);
    applyStimulus(8'd50, 8'h23, 1'b1);
    runTo(c + 260);
    checkOutput("s2_no_early", 16'(busy), 16'd0);
    t = c + 100 + ST + 1;
    runTo(t);
    checkOutput("s2_busy_pre", 16'(busy), 16'd0);
    runTo(t + 1);
    checkOutput("s2_busy_start", 16'(busy), 16'd1);
    runTo(t + SEQ);
    checkOutput("s2_m", 16'(pll_m), 16'd50);
    checkOutput("s2_n", 16'(pll_n), 16'd3);
    checkOutput("s2_od", 16'(pll_od), 16'd1);
    checkOutput("s2_busy_end", 16'(busy), 16'd0);
    runTo(t + SEQ + 300);
    checkOutput("s2_single", 16'(busy), 16'd0);

    // Illegal M is rejected, cfg_oe only steers pll_oe, then a legal M clears the error
    c = cyc;
    applyStimulus(8'd200, 8'h23, 1'b1);
    t = c + ST + 1;
    runTo(t);
    checkOutput("e_err_pre", 16'(cfg_err), 16'd0);
    runTo(t + 1);
    checkOutput("e_err_set", 16'(cfg_err), 16'd1);
    checkOutput("e_busy", 16'(busy), 16'd0);
    checkOutput("e_oe", 16'(pll_oe), 16'd1);
    runTo(t + 20);
    applyStimulus(8'd200, 8'h23, 1'b0);
    stepCycle();
    checkOutput("e_oe_off", 16'(pll_oe), 16'd0);
    checkOutput("e_oe_nobusy", 16'(busy), 16'd0);
    applyStimulus(8'd200, 8'h23, 1'b1);
    stepCycle();
    checkOutput("e_oe_on", 16'(pll_oe), 16'd1);
    checkOutput("e_m_kept", 16'(pll_m), 16'd50);
    c = cyc;
    applyStimulus(8'd40, 8'h23, 1'b1);
    t = c + ST + 1;
    runTo(t);
    checkOutput("e_err_hold", 16'(cfg_err), 16'd1);
    runTo(t + 1);
    checkOutput("e_err_clr", 16'(cfg_err), 16'd0);
    checkOutput("e_busy_seq", 16'(busy), 16'd1);
    runTo(t + SEQ);
    checkOutput("e_m", 16'(pll_m), 16'd40);
    checkOutput("e_busy_end", 16'(busy), 16'd0);

    // Change during LOCK: old value finishes, a second sequence applies the new one
    c = cyc;
    applyStimulus(8'd60, 8'h23, 1'b1);
    t = c + ST + 1;
    runTo(t + G + R + 50);
    applyStimulus(8'd70, 8'h23, 1'b1);
    runTo(t + SEQ - 1);
    checkOutput("l_m_old", 16'(pll_m), 16'd60);
    runTo(t + SEQ);
    checkOutput("l_dom_gap", 16'(domain_rst_req), 16'd0);
    checkOutput("l_busy_gap", 16'(busy), 16'd0);
    runTo(t + SEQ + 1);
    checkOutput("l_busy_2nd", 16'(busy), 16'd1);
    checkOutput("l_oe_2nd", 16'(pll_oe), 16'd0);
    runTo(t + SEQ + SEQ);
    checkOutput("l_m_new", 16'(pll_m), 16'd70);
    checkOutput("l_dom_end", 16'(domain_rst_req), 16'd0);

    // Asynchronous reset during LOCK of an M=30 sequence
    c = cyc;
    applyStimulus(8'd30, 8'h23, 1'b1);
    t = c + ST + 1;
    runTo(t + G + R + 100);
    checkOutput("ar_m_flight", 16'(pll_m), 16'd30);
    checkOutput("ar_busy_flight", 16'(busy), 16'd1);
    #5;
    reset = 1'b1;
    #1;
    checkOutput("ar_m", 16'(pll_m), 16'd46);
    checkOutput("ar_n", 16'(pll_n), 16'd2);
    checkOutput("ar_dom", 16'(domain_rst_req), 16'd1);
    checkOutput("ar_oe", 16'(pll_oe), 16'd0);
    applyStimulus(8'd46, 8'h22, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;
    runTo(L + S);
    checkOutput("ar_dom_hold", 16'(domain_rst_req), 16'd1);
    runTo(L + S + 1);
    checkOutput("ar_dom_rel", 16'(domain_rst_req), 16'd0);
    checkOutput("ar_m_end", 16'(pll_m), 16'd46);
    runTo(L + S + 300);
    checkOutput("ar_idle", 16'(busy), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
